// File: rtl/mc_stream_mmio_responder_if.sv
// Request/response stream and local MMIO port bundle for mc_stream_mmio_responder.
// slave = responder side, master = link initiator plus local memory side.
interface mc_stream_mmio_responder_if #(
    parameter int unsigned stream_data_width_p = 16,
    parameter int unsigned data_width_p        = 32,
    parameter int unsigned addr_width_p        = 28,
    parameter int unsigned x_cord_width_p      = 7,
    parameter int unsigned y_cord_width_p      = 7
);
    logic                           stream_v_i;
    logic [stream_data_width_p-1:0] stream_data_i;
    logic                           stream_yumi_o;
    logic                           stream_v_o;
    logic [stream_data_width_p-1:0] stream_data_o;
    logic                           stream_ready_i;
    logic                           mem_v_o;
    logic                           mem_w_o;
    logic [addr_width_p-1:0]        mem_addr_o;
    logic [data_width_p-1:0]        mem_data_o;
    logic [data_width_p/8-1:0]      mem_mask_o;
    logic [x_cord_width_p-1:0]      mem_src_x_o;
    logic [y_cord_width_p-1:0]      mem_src_y_o;
    logic                           mem_ready_i;
    logic                           mem_rdata_v_i;
    logic [data_width_p-1:0]        mem_rdata_i;

    modport slave (
        input  stream_v_i, stream_data_i, stream_ready_i,
        input  mem_ready_i, mem_rdata_v_i, mem_rdata_i,
        output stream_yumi_o, stream_v_o, stream_data_o,
        output mem_v_o, mem_w_o, mem_addr_o, mem_data_o, mem_mask_o, mem_src_x_o, mem_src_y_o
    );

    modport master (
        output stream_v_i, stream_data_i, stream_ready_i,
        output mem_ready_i, mem_rdata_v_i, mem_rdata_i,
        input  stream_yumi_o, stream_v_o, stream_data_o,
        input  mem_v_o, mem_w_o, mem_addr_o, mem_data_o, mem_mask_o, mem_src_x_o, mem_src_y_o
    );
endinterface

// File: rtl/mc_stream_mmio_responder.sv
// Far-end MMIO responder: reassembles a 96-bit request from flits, issues one access, and
// serializes read data back. Optional read timeout enabled by MC_STREAM_MMIO_RSP_TIMEOUT_EN.
module mc_stream_mmio_responder #(
    parameter int unsigned stream_data_width_p = 16,
    parameter int unsigned data_width_p        = 32,
    parameter int unsigned addr_width_p        = 28,
    parameter int unsigned x_cord_width_p      = 7,
    parameter int unsigned y_cord_width_p      = 7,
    parameter int unsigned timeout_p           = 1024
) (
    input  logic                      clk_i,
    input  logic                      reset_n_i,
    mc_stream_mmio_responder_if.slave bus,
    output logic                      err_o
);
    localparam int unsigned PktW     = 96;
    localparam int unsigned NumFlits = (PktW + stream_data_width_p - 1) / stream_data_width_p;
    localparam int unsigned RspFlits = data_width_p / stream_data_width_p;
    localparam int unsigned FlitCntW = $clog2(NumFlits);
    localparam int unsigned TxCntW   = (RspFlits > 1) ? $clog2(RspFlits) : 1;

    typedef enum logic [1:0] {StRx, StReq, StWait, StTx} state_e;

    state_e                                       state_q;
    logic [NumFlits-1:0][stream_data_width_p-1:0] pkt_q;
    logic [RspFlits-1:0][stream_data_width_p-1:0] rsp_q;
    logic [FlitCntW-1:0]                          flit_cnt_q;
    logic [TxCntW-1:0]                            tx_cnt_q;
    logic [NumFlits*stream_data_width_p-1:0]      pkt_flat;

`ifdef MC_STREAM_MMIO_RSP_TIMEOUT_EN
    localparam int unsigned WaitCntW    = $clog2(timeout_p) + 1;
    localparam logic [31:0] TimeoutWord = 32'hDEAD_BEEF;
    logic [WaitCntW-1:0] wait_cnt_q;
    logic                err_q;
`endif

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q    <= StRx;
            pkt_q      <= '0;
            rsp_q      <= '0;
            flit_cnt_q <= '0;
            tx_cnt_q   <= '0;
`ifdef MC_STREAM_MMIO_RSP_TIMEOUT_EN
            wait_cnt_q <= '0;
            err_q      <= 1'b0;
`endif
        end else begin
            unique case (state_q)
                StRx: begin
                    if (bus.stream_v_i) begin
                        pkt_q[flit_cnt_q] <= bus.stream_data_i;
                        if (flit_cnt_q == FlitCntW'(NumFlits - 1)) begin
                            flit_cnt_q <= '0;
                            state_q    <= StReq;
                        end else begin
                            flit_cnt_q <= flit_cnt_q + 1'b1;
                        end
                    end
                end
                StReq: begin
`ifdef MC_STREAM_MMIO_RSP_TIMEOUT_EN
                    wait_cnt_q <= '0;
`endif
                    if (bus.mem_ready_i) begin
                        state_q <= pkt_flat[16] ? StRx : StWait;
                    end
                end
                StWait: begin
                    if (bus.mem_rdata_v_i) begin
                        rsp_q   <= bus.mem_rdata_i;
                        state_q <= StTx;
`ifdef MC_STREAM_MMIO_RSP_TIMEOUT_EN
                    end else if (wait_cnt_q == WaitCntW'(timeout_p - 1)) begin
                        rsp_q   <= TimeoutWord[data_width_p-1:0];
                        err_q   <= 1'b1;
                        state_q <= StTx;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + 1'b1;
`endif
                    end
                end
                StTx: begin
                    if (bus.stream_ready_i) begin
                        if (tx_cnt_q == TxCntW'(RspFlits - 1)) begin
                            tx_cnt_q <= '0;
                            state_q  <= StRx;
                        end else begin
                            tx_cnt_q <= tx_cnt_q + 1'b1;
                        end
                    end
                end
                default: state_q <= StRx;
            endcase
        end
    end

    assign pkt_flat = pkt_q;

    assign bus.stream_yumi_o = (state_q == StRx) && bus.stream_v_i;
    assign bus.stream_v_o    = (state_q == StTx);
    assign bus.stream_data_o = rsp_q[tx_cnt_q];

    // Fields come straight from the packet register, so they hold while REQ stalls.
    assign bus.mem_v_o     = (state_q == StReq);
    assign bus.mem_w_o     = pkt_flat[16];
    assign bus.mem_src_x_o = pkt_flat[0 +: x_cord_width_p];
    assign bus.mem_src_y_o = pkt_flat[8 +: y_cord_width_p];
    assign bus.mem_mask_o  = pkt_flat[24 +: data_width_p/8];
    assign bus.mem_addr_o  = pkt_flat[32 +: addr_width_p];
    assign bus.mem_data_o  = pkt_flat[64 +: data_width_p];

    // Ignored we-byte bits, truncated field bits and padding above bit 95.
    logic unused_pkt;
    assign unused_pkt = ^pkt_flat;

`ifdef MC_STREAM_MMIO_RSP_TIMEOUT_EN
    assign err_o = err_q;
`else
    assign err_o = 1'b0;
    logic unused_timeout;
    assign unused_timeout = (timeout_p == 0);
`endif
endmodule

// File: tb/tb_mc_stream_mmio_responder.sv
// Directed self-checking bench for mc_stream_mmio_responder (W=16, D=32); the timeout
// scenario runs only when MC_STREAM_MMIO_RSP_TIMEOUT_EN is defined.
module tb_mc_stream_mmio_responder;
    logic clk_i = 1'b0;
    logic reset_n_i = 1'b0;
    logic err_o;
    int   checks = 0;
    int   errors = 0;
    int   tx_count = 0;
    int   waited;

    logic [95:0] wr_pkt  = 96'hDEADBEEF_00001000_0F01_0304;
    logic [95:0] rd_pkt  = 96'hDEADBEEF_00001000_0F00_0304;
    logic [95:0] rst_pkt = 96'h00000000_00002000_0F01_0304;
    logic [95:0] new_pkt = 96'h55AA33CC_0ABCDEF0_0301_2211;

    mc_stream_mmio_responder_if #(
        .stream_data_width_p(16), .data_width_p(32), .addr_width_p(28),
        .x_cord_width_p(7), .y_cord_width_p(7)
    ) bus ();

    mc_stream_mmio_responder #(
        .stream_data_width_p(16), .data_width_p(32), .addr_width_p(28),
        .x_cord_width_p(7), .y_cord_width_p(7), .timeout_p(8)
    ) dut (
        .clk_i    (clk_i),
        .reset_n_i(reset_n_i),
        .bus      (bus),
        .err_o    (err_o)
    );

    always #5 clk_i = ~clk_i;

    // Response flits handed off (handshake seen just before the rising edge).
    always @(negedge clk_i) begin
        if (reset_n_i && bus.stream_v_o && bus.stream_ready_i) tx_count++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic send(input logic [95:0] pkt, input int n);
        for (int i = 0; i < n; i++) begin
            bus.stream_v_i    = 1'b1;
            bus.stream_data_i = pkt[i*16 +: 16];
            @(negedge clk_i);
            check("rx_yumi", {31'b0, bus.stream_yumi_o}, 32'd1);
            check("rx_mem_v_low", {31'b0, bus.mem_v_o}, 32'd0);
            tick();
        end
        bus.stream_v_i = 1'b0;
    endtask

    task automatic check_req(input string tag, input logic w, input logic [31:0] addr,
                             input logic [31:0] data, input logic [31:0] mask,
                             input logic [31:0] x, input logic [31:0] y);
        check({tag, "_v"}, {31'b0, bus.mem_v_o}, 32'd1);
        check({tag, "_w"}, {31'b0, bus.mem_w_o}, {31'b0, w});
        check({tag, "_addr"}, {4'b0, bus.mem_addr_o}, addr);
        check({tag, "_data"}, bus.mem_data_o, data);
        check({tag, "_mask"}, {28'b0, bus.mem_mask_o}, mask);
        check({tag, "_x"}, {25'b0, bus.mem_src_x_o}, x);
        check({tag, "_y"}, {25'b0, bus.mem_src_y_o}, y);
    endtask

    initial begin
        bus.stream_v_i     = 1'b0;
        bus.stream_data_i  = '0;
        bus.stream_ready_i = 1'b1;
        bus.mem_ready_i    = 1'b0;
        bus.mem_rdata_v_i  = 1'b0;
        bus.mem_rdata_i    = '0;

        // Reset values
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        check("rst_yumi", {31'b0, bus.stream_yumi_o}, 32'd0);
        check("rst_stream_v", {31'b0, bus.stream_v_o}, 32'd0);
        check("rst_mem_v", {31'b0, bus.mem_v_o}, 32'd0);
        check("rst_err", {31'b0, err_o}, 32'd0);
        check("rst_addr", {4'b0, bus.mem_addr_o}, 32'd0);
        check("rst_data", bus.mem_data_o, 32'd0);
        check("rst_sdata", {16'b0, bus.stream_data_o}, 32'd0);
        tick();
        reset_n_i = 1'b1;

        // Stray read data in RX is ignored
        bus.mem_rdata_v_i = 1'b1;
        bus.mem_rdata_i   = 32'hFFFF_FFFF;
        tick();
        bus.mem_rdata_v_i = 1'b0;
        @(negedge clk_i);
        check("stray_rdata", {31'b0, bus.stream_v_o}, 32'd0);
        tick();

        // Write, with mem_ready_i held low for 10 REQ cycles
        send(wr_pkt, 6);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk_i);
            check_req("wr_stall", 1'b1, 32'h1000, 32'hDEADBEEF, 32'hF, 32'h4, 32'h3);
            tick();
        end
        bus.mem_ready_i = 1'b1;
        @(negedge clk_i);
        check_req("wr_accept", 1'b1, 32'h1000, 32'hDEADBEEF, 32'hF, 32'h4, 32'h3);
        tick();
        check("wr_no_resp", tx_count, 0);

        // Read: immediately follows the write (yumi in M+1)
        send(rd_pkt, 6);
        @(negedge clk_i);
        check_req("rd_req", 1'b0, 32'h1000, 32'hDEADBEEF, 32'hF, 32'h4, 32'h3);
        tick();
        bus.mem_ready_i = 1'b0;
        @(negedge clk_i);
        check("rd_wait_v", {31'b0, bus.stream_v_o}, 32'd0);
        check("rd_wait_mem_v", {31'b0, bus.mem_v_o}, 32'd0);
        tick();
        bus.mem_rdata_v_i = 1'b1;
        bus.mem_rdata_i   = 32'h1234_5678;
        @(negedge clk_i);
        check("rd_r_v", {31'b0, bus.stream_v_o}, 32'd0);
        tick();
        bus.mem_rdata_v_i = 1'b0;
        bus.mem_rdata_i   = '0;
        @(negedge clk_i);
        check("rd_f0_v", {31'b0, bus.stream_v_o}, 32'd1);
        check("rd_f0", {16'b0, bus.stream_data_o}, 32'h5678);
        tick();
        @(negedge clk_i);
        check("rd_f1_v", {31'b0, bus.stream_v_o}, 32'd1);
        check("rd_f1", {16'b0, bus.stream_data_o}, 32'h1234);
        tick();
        @(negedge clk_i);
        check("rd_done_v", {31'b0, bus.stream_v_o}, 32'd0);
        check("rd_count", tx_count, 2);

        // Backpressure on the response, request flit pending meanwhile
        bus.stream_ready_i = 1'b0;
        bus.mem_ready_i    = 1'b1;
        tick();
        send(rd_pkt, 6);
        tick();
        bus.mem_ready_i   = 1'b0;
        bus.mem_rdata_v_i = 1'b1;
        bus.mem_rdata_i   = 32'hCAFE_F00D;
        tick();
        bus.mem_rdata_v_i = 1'b0;
        bus.stream_v_i    = 1'b1;
        bus.stream_data_i = 16'h0304;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_i);
            check("bp_v", {31'b0, bus.stream_v_o}, 32'd1);
            check("bp_data", {16'b0, bus.stream_data_o}, 32'hF00D);
            check("bp_yumi", {31'b0, bus.stream_yumi_o}, 32'd0);
            tick();
        end
        bus.stream_ready_i = 1'b1;
        @(negedge clk_i);
        check("bp_f0", {16'b0, bus.stream_data_o}, 32'hF00D);
        check("bp_f0_yumi", {31'b0, bus.stream_yumi_o}, 32'd0);
        tick();
        @(negedge clk_i);
        check("bp_f1", {16'b0, bus.stream_data_o}, 32'hCAFE);
        check("bp_f1_yumi", {31'b0, bus.stream_yumi_o}, 32'd0);
        tick();
        bus.stream_v_i = 1'b0;
        @(negedge clk_i);
        check("bp_done_v", {31'b0, bus.stream_v_o}, 32'd0);
        check("bp_count", tx_count, 4);
        tick();

        // Reset after 3 of 6 request flits
        send(rst_pkt, 3);
        reset_n_i = 1'b0;
        @(negedge clk_i);
        check("mid_rst_yumi", {31'b0, bus.stream_yumi_o}, 32'd0);
        check("mid_rst_mem_v", {31'b0, bus.mem_v_o}, 32'd0);
        check("mid_rst_stream_v", {31'b0, bus.stream_v_o}, 32'd0);
        check("mid_rst_addr", {4'b0, bus.mem_addr_o}, 32'd0);
        check("mid_rst_mask", {28'b0, bus.mem_mask_o}, 32'd0);
        check("mid_rst_x", {25'b0, bus.mem_src_x_o}, 32'd0);
        tick();
        reset_n_i       = 1'b1;
        bus.mem_ready_i = 1'b1;
        send(new_pkt, 6);
        @(negedge clk_i);
        check_req("post_rst", 1'b1, 32'h0ABCDEF0, 32'h55AA33CC, 32'h3, 32'h11, 32'h22);
        tick();
        @(negedge clk_i);
        check("post_rst_mem_v", {31'b0, bus.mem_v_o}, 32'd0);
        check("post_rst_count", tx_count, 4);

`ifdef MC_STREAM_MMIO_RSP_TIMEOUT_EN
        // Read with no rdata: timeout after 8 WAIT cycles
        tick();
        send(rd_pkt, 6);
        tick();
        bus.mem_ready_i = 1'b0;
        waited = 0;
        @(negedge clk_i);
        while (!bus.stream_v_o && waited < 40) begin
            waited++;
            tick();
            @(negedge clk_i);
        end
        check("to_wait_cycles", waited, 8);
        check("to_f0", {16'b0, bus.stream_data_o}, 32'hBEEF);
        check("to_err", {31'b0, err_o}, 32'd1);
        tick();
        @(negedge clk_i);
        check("to_f1", {16'b0, bus.stream_data_o}, 32'hDEAD);
        tick();
        repeat (3) tick();
        @(negedge clk_i);
        check("to_err_sticky", {31'b0, err_o}, 32'd1);
        check("to_count", tx_count, 6);
`else
        tick();
        @(negedge clk_i);
        check("err_tied_low", {31'b0, err_o}, 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
